mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles in ACCESS before the access is abandoned as a fault.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_mem_is_load / ex_mem_is_store  in  1 each  memory operation request from the EX/MEM register; asserting both is illegal.
REQ-005 ex_mem_load_type / ex_mem_store_type  in  3 each  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
REQ-006 ex_mem_ram_address  in  32  byte address; ex_mem_rs2_val  in  32  store data; ex_mem_result  in  32  ALU result.
REQ-007 ex_mem_rd_addr  in  5  destination register; ex_mem_reg_write  in  1  write-back enable.
REQ-008 mem_req  out  1  RAM request; mem_we  out  1  write enable; mem_addr  out  32  word address, bits[1:0]=00; mem_wstrb  out  4  byte lanes; mem_wdata  out  32  lane-aligned write data.
REQ-009 mem_rdata  in  32  RAM read word; mem_ready  in  1  RAM completion, valid only while mem_req=1.
REQ-010 mem_busy  out  1  stall request to the pipeline; mem_fault  out  1  one-cycle misaligned, illegal-type or timeout pulse.
REQ-011 mem_wb_rd  out  5; mem_wb_result  out  32; mem_wb_write  out  1  MEM/WB write-back triple.

Function
REQ-012 States: IDLE and ACCESS.
REQ-013 Capture in IDLE:
- Any cycle with mem_busy=0 captures the EX/MEM inputs.
- Non-memory op: mem_wb_result<=ex_mem_result, mem_wb_rd<=ex_mem_rd_addr, mem_wb_write<=ex_mem_reg_write; 1-cycle latency.
REQ-014 Fault ops: a load or store that is misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00) or has an unlisted funct3 SHALL:
- issue no RAM request;
- pulse mem_fault the next cycle with mem_wb_write=0.
- Both is_load and is_store set is handled as an illegal type.
REQ-015 Valid memory op in IDLE: mem_busy=1 combinationally in the same cycle; the op is latched; state->ACCESS next edge.
REQ-016 ACCESS:
- mem_req=1 and mem_busy=1; mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_ready.
REQ-017 Store lanes:
- SB: wstrb=0001<<addr[1:0], wdata=byte replicated x4.
- SH: wstrb=0011<<{addr[1],1'b0}, wdata=half replicated x2.
- SW: wstrb=1111, wdata=rs2.
- Loads: wstrb=0000.
REQ-018 On mem_ready=1 in ACCESS:
- Next edge: state->IDLE, mem_req=0, mem_busy=0.
- Load: mem_wb_result is the selected byte/half shifted by addr[1:0] and sign- (LB/LH) or zero-extended (LBU/LHU), or the full word (LW); mem_wb_write=latched reg_write.
- Store: mem_wb_write=0.
REQ-019 Minimum memory-op latency: 2 cycles (capture, ACCESS with same-cycle mem_ready); each extra wait cycle adds 1.
REQ-020 An ACCESS cycle counter is cleared on entry. If the counter reaches TIMEOUT without mem_ready:
- mem_req drops;
- mem_fault pulses;
- mem_wb_write=0;
- state returns to IDLE.
REQ-021 mem_wb outputs hold their values while mem_busy=1; mem_wb_write is 0 during every ACCESS cycle, so no write-back is duplicated.
REQ-022 A mem_ready received while mem_req=0 SHALL be ignored.
REQ-023 rd=0 SHALL be passed through unchanged; the register file suppresses the write.

Reset
REQ-024 While reset=1 at an edge:
- state->IDLE, counter->0.
- mem_req, mem_we, mem_busy, mem_fault, mem_wb_write -> 0; mem_wstrb -> 0000; mem_wb_rd -> 0; mem_wb_result -> 0.
REQ-025 Reset asserted during ACCESS SHALL deassert mem_req at the following edge and discard the pending op; no write-back and no fault.

Verification
REQ-026 ALU pass-through: result=0x1234, rd=5, reg_write=1 -> next cycle mem_wb_result=0x1234, mem_wb_rd=5, mem_wb_write=1, mem_busy=0.
REQ-027 LB to addr 0x103 with mem_rdata=0x80FFFFFF and mem_ready after 3 ACCESS cycles:
- mem_addr=0x100, mem_busy high for 4 cycles;
- mem_wb_result=0xFFFFFF80.
- LBU of the same address -> 0x00000080.
REQ-028 SH at addr 0x202 with rs2=0xAABBCCDD -> mem_we=1, mem_addr=0x200, wstrb=1100, wdata=0xCCDDCCDD, mem_wb_write=0.
REQ-029 LW at addr 0x6 -> no mem_req, mem_fault=1 for exactly one cycle, mem_wb_write=0.
REQ-030 TIMEOUT=4 with mem_ready held low -> mem_req high for 4 cycles, then mem_fault pulse; a mem_ready arriving afterwards is ignored.
REQ-031 Reset in the second ACCESS cycle of an SW -> mem_req=0 next cycle, all outputs at reset values, no fault.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of a RISC-V pipeline: ALU pass-through, load/store RAM handshake with
// byte-lane steering, misalignment/illegal-type faults and an access timeout.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_is_load,
    input  logic        ex_mem_is_store,
    input  logic [2:0]  ex_mem_load_type,
    input  logic [2:0]  ex_mem_store_type,
    input  logic [31:0] ex_mem_ram_address,
    input  logic [31:0] ex_mem_rs2_val,
    input  logic [31:0] ex_mem_result,
    input  logic [4:0]  ex_mem_rd_addr,
    input  logic        ex_mem_reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_fault,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_write
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    typedef struct packed {
        logic       is_store;
        logic [2:0] ld_type;
        logic [1:0] off;
        logic [4:0] rd;
        logic       reg_write;
    } op_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               op_q, op_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_result_q, wb_result_d;
    logic              wb_write_q, wb_write_d;

    logic        mem_op_c, legal_c, misal_c, go_c, bad_c;
    logic [1:0]  addr_lo_c;
    logic [3:0]  st_strb_c;
    logic [31:0] st_data_c;
    logic [31:0] lane_c;
    logic [31:0] ld_val_c;

    // Decode the EX/MEM request: legality, alignment and store lane steering.
    always_comb begin
        legal_c   = 1'b0;
        misal_c   = 1'b0;
        st_strb_c = 4'b0000;
        st_data_c = 32'h0;
        addr_lo_c = ex_mem_ram_address[1:0];
        if (ex_mem_is_load && !ex_mem_is_store) begin
            case (ex_mem_load_type)
                F_B, F_BU: legal_c = 1'b1;
                F_H, F_HU: begin
                    legal_c = 1'b1;
                    misal_c = addr_lo_c[0];
                end
                F_W: begin
                    legal_c = 1'b1;
                    misal_c = |addr_lo_c;
                end
                default: legal_c = 1'b0;
            endcase
        end else if (ex_mem_is_store && !ex_mem_is_load) begin
            case (ex_mem_store_type)
                F_B: begin
                    legal_c   = 1'b1;
                    st_strb_c = 4'b0001 << addr_lo_c;
                    st_data_c = {4{ex_mem_rs2_val[7:0]}};
                end
                F_H: begin
                    legal_c   = 1'b1;
                    misal_c   = addr_lo_c[0];
                    st_strb_c = 4'b0011 << {addr_lo_c[1], 1'b0};
                    st_data_c = {2{ex_mem_rs2_val[15:0]}};
                end
                F_W: begin
                    legal_c   = 1'b1;
                    misal_c   = |addr_lo_c;
                    st_strb_c = 4'b1111;
                    st_data_c = ex_mem_rs2_val;
                end
                default: legal_c = 1'b0;
            endcase
        end
        mem_op_c = ex_mem_is_load | ex_mem_is_store;
        go_c     = mem_op_c & legal_c & ~misal_c;
        bad_c    = mem_op_c & ~go_c;
    end

    // Load data: shift the addressed lane down, then extend.
    always_comb begin
        lane_c = mem_rdata >> {op_q.off, 3'b000};
        case (op_q.ld_type)
            F_B:     ld_val_c = {{24{lane_c[7]}}, lane_c[7:0]};
            F_BU:    ld_val_c = {24'h0, lane_c[7:0]};
            F_H:     ld_val_c = {{16{lane_c[15]}}, lane_c[15:0]};
            F_HU:    ld_val_c = {16'h0, lane_c[15:0]};
            default: ld_val_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        fault_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        wb_write_d  = wb_write_q;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d   = S_ACCESS;
                    cnt_d     = '0;
                    we_d      = ex_mem_is_store;
                    addr_d    = {ex_mem_ram_address[31:2], 2'b00};
                    wstrb_d   = st_strb_c;
                    wdata_d   = st_data_c;
                    op_d      = '{is_store:  ex_mem_is_store,
                                  ld_type:   ex_mem_load_type,
                                  off:       addr_lo_c,
                                  rd:        ex_mem_rd_addr,
                                  reg_write: ex_mem_reg_write};
                    wb_write_d = 1'b0;
                end else if (bad_c) begin
                    fault_d    = 1'b1;
                    wb_write_d = 1'b0;
                end else begin
                    wb_result_d = ex_mem_result;
                    wb_rd_d     = ex_mem_rd_addr;
                    wb_write_d  = ex_mem_reg_write;
                end
            end
            S_ACCESS: begin
                wb_write_d = 1'b0;
                if (mem_ready) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    if (!op_q.is_store) begin
                        wb_result_d = ld_val_c;
                        wb_rd_d     = op_q.rd;
                        wb_write_d  = op_q.reg_write;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the access; the RAM never answered.
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_result_q <= 32'h0;
            wb_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            wb_write_q  <= wb_write_d;
        end
    end

    // Busy rises combinationally so the pipeline stalls in the capture cycle.
    assign mem_busy      = (state_q == S_ACCESS) || go_c;
    assign mem_req       = (state_q == S_ACCESS);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign mem_fault     = fault_q;
    assign mem_wb_rd     = wb_rd_q;
    assign mem_wb_result = wb_result_q;
    assign mem_wb_write  = wb_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a byte-lane reference model.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_load, is_store;
    logic [2:0]  load_type, store_type;
    logic [31:0] ram_address, rs2_val, alu_result;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_req, mem_we, mem_busy, mem_fault, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_result;
    logic        mem_wb_write;

    int checks = 0;
    int errors = 0;

    int          o_busy, o_req;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we, o_stable, o_done, o_fault;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_mem_is_load(is_load), .ex_mem_is_store(is_store),
        .ex_mem_load_type(load_type), .ex_mem_store_type(store_type),
        .ex_mem_ram_address(ram_address), .ex_mem_rs2_val(rs2_val),
        .ex_mem_result(alu_result), .ex_mem_rd_addr(rd_addr), .ex_mem_reg_write(reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_busy(mem_busy), .mem_fault(mem_fault),
        .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result), .mem_wb_write(mem_wb_write)
    );

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] ty);
        case (ty[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic ld, input logic st, input logic [2:0] ty,
                                    input logic [31:0] a);
        int sz = op_size(ty);
        if (ld == st) return 1'b0;
        if (ld && !(ty inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (st && ty > 3'd2) return 1'b0;
        return (a % 32'(sz)) == 32'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] ty, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (a % 4));
        case (ty)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] ty, input logic [31:0] a);
        logic [3:0] s = 4'b0000;
        int off = int'(a % 4);
        for (int lane = 0; lane < 4; lane++)
            if (lane >= off && lane < off + op_size(ty)) s[lane] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] ty, input logic [31:0] d);
        logic [31:0] w = 32'h0;
        int sz = op_size(ty);
        for (int lane = 0; lane < 4; lane++)
            w[8*lane +: 8] = d[8*(lane % sz) +: 8];
        return w;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        is_load = 1'b0; is_store = 1'b0; load_type = 3'd0; store_type = 3'd0;
        ram_address = 32'h0; rs2_val = 32'h0; alu_result = 32'h0; rd_addr = 5'd0; reg_write = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] res,
                         input logic [4:0] r, input logic w);
        is_load = ld; is_store = st; load_type = ty; store_type = ty;
        ram_address = a; rs2_val = d; alu_result = res; rd_addr = r; reg_write = w;
    endtask

    // Runs the op currently on the inputs; RAM answers on ACCESS cycle wait_n+1.
    task automatic run_op(input logic [31:0] rdata, input int wait_n);
        o_busy = 0; o_req = 0; o_stable = 1'b1; o_done = 1'b0; o_fault = 1'b0;
        o_addr = 32'h0; o_wdata = 32'h0; o_wstrb = 4'h0; o_we = 1'b0;
        mem_rdata = rdata;
        for (int c = 0; c < 20 && !o_done; c++) begin
            #1;
            if (mem_busy) o_busy++;
            if (mem_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = mem_addr; o_we = mem_we; o_wstrb = mem_wstrb; o_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {o_addr, o_we, o_wstrb, o_wdata}) begin
                    o_stable = 1'b0;
                end
                mem_ready = (o_req == wait_n + 1);
            end
            tick;
            mem_ready = 1'b0;
            set_idle;
            if (!mem_req) o_done = 1'b1;
        end
        o_fault = mem_fault;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; set_idle; mem_ready = 1'b0; mem_rdata = 32'h0;
        tick; tick;
        checks++;
        if ({mem_req, mem_we, mem_busy, mem_fault, mem_wb_write, mem_wstrb, mem_wb_rd, mem_wb_result} !== 45'h0) begin
            errors++;
            $display("FAIL reset_values: got req=%b we=%b busy=%b fault=%b wbw=%b strb=%b rd=%0d res=%h expected all zero",
                     mem_req, mem_we, mem_busy, mem_fault, mem_wb_write, mem_wstrb, mem_wb_rd, mem_wb_result);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_alu;
        logic [31:0] res;
        logic [4:0]  r;
        logic        w;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
        run_op(32'h0, 0);
        checks++;
        if ({mem_wb_result, mem_wb_rd, mem_wb_write, 32'(o_busy), 32'(o_req)} !== {32'h1234, 5'd5, 1'b1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL alu_pass: got res=%h rd=%0d w=%b busy=%0d req=%0d expected 1234/5/1/0/0",
                     mem_wb_result, mem_wb_rd, mem_wb_write, o_busy, o_req);
        end
        for (int i = 0; i < 6; i++) begin
            res = $urandom; r = (i == 0) ? 5'd0 : 5'($urandom); w = 1'($urandom);
            drive(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, res, r, w);
            run_op($urandom, 0);
            checks++;
            if ({mem_wb_result, mem_wb_rd, mem_wb_write, o_fault} !== {res, r, w, 1'b0}) begin
                errors++;
                $display("FAIL alu_rand%0d: got %h/%0d/%b fault=%b expected %h/%0d/%b fault=0",
                         i, mem_wb_result, mem_wb_rd, mem_wb_write, o_fault, res, r, w);
            end
        end
    endtask

    task automatic test_load_byte;
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd9, 1'b1);
        run_op(32'h80FF_FFFF, 2);
        checks++;
        if ({o_addr, o_we, o_wstrb, o_stable, 32'(o_busy), 32'(o_req)} !== {32'h100, 1'b0, 4'h0, 1'b1, 32'd4, 32'd3}) begin
            errors++;
            $display("FAIL lb_handshake: got addr=%h we=%b strb=%b stable=%b busy=%0d req=%0d expected 100/0/0000/1/4/3",
                     o_addr, o_we, o_wstrb, o_stable, o_busy, o_req);
        end
        checks++;
        if ({mem_wb_result, mem_wb_rd, mem_wb_write} !== {32'hFFFF_FF80, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL lb_result: got %h/%0d/%b expected ffffff80/9/1", mem_wb_result, mem_wb_rd, mem_wb_write);
        end
        drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 5'd9, 1'b1);
        run_op(32'h80FF_FFFF, 2);
        checks++;
        if ({mem_wb_result, mem_wb_write} !== {32'h0000_0080, 1'b1}) begin
            errors++;
            $display("FAIL lbu_result: got %h/%b expected 00000080/1", mem_wb_result, mem_wb_write);
        end
    endtask

    task automatic test_store_half;
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'hAABB_CCDD, 32'h0, 5'd7, 1'b1);
        run_op(32'h0, 0);
        checks++;
        if ({o_we, o_addr, o_wstrb, o_wdata, mem_wb_write, 32'(o_busy)} !== {1'b1, 32'h200, 4'b1100, 32'hCCDD_CCDD, 1'b0, 32'd2}) begin
            errors++;
            $display("FAIL sh_lanes: got we=%b addr=%h strb=%b wdata=%h wbw=%b busy=%0d expected 1/200/1100/ccddccdd/0/2",
                     o_we, o_addr, o_wstrb, o_wdata, mem_wb_write, o_busy);
        end
    endtask

    task automatic test_fault;
        logic [1:0]  ld_st [4] = '{2'b10, 2'b11, 2'b10, 2'b01};
        logic [2:0]  tys   [4] = '{3'b010, 3'b010, 3'b011, 3'b100};
        logic [31:0] adrs  [4] = '{32'h6, 32'h40, 32'h40, 32'h40};
        for (int i = 0; i < 4; i++) begin
            drive(ld_st[i][1], ld_st[i][0], tys[i], adrs[i], 32'h55, 32'h0, 5'd3, 1'b1);
            run_op(32'h0, 0);
            checks++;
            if ({32'(o_req), 32'(o_busy), o_fault, mem_wb_write} !== {32'd0, 32'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL fault_case%0d: got req=%0d busy=%0d fault=%b wbw=%b expected 0/0/1/0",
                         i, o_req, o_busy, o_fault, mem_wb_write);
            end
            tick;
            checks++;
            if ({mem_fault, mem_req} !== 2'b00) begin
                errors++;
                $display("FAIL fault_width%0d: got fault=%b req=%b expected 0/0", i, mem_fault, mem_req);
            end
        end
    endtask

    task automatic test_timeout;
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd4, 1'b1);
        run_op(32'h1111_2222, 100);
        checks++;
        if ({32'(o_req), 32'(o_busy), o_fault, mem_wb_write} !== {32'(TO), 32'(TO + 1), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout: got req=%0d busy=%0d fault=%b wbw=%b expected %0d/%0d/1/0",
                     o_req, o_busy, o_fault, mem_wb_write, TO, TO + 1);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        checks++;
        if ({mem_req, mem_fault, mem_wb_write, mem_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL late_ready: got req=%b fault=%b wbw=%b busy=%b expected 0000",
                     mem_req, mem_fault, mem_wb_write, mem_busy);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 5'd6, 1'b1);
        run_op(32'hCAFE_F00D, TO - 1);
        checks++;
        if ({mem_wb_result, mem_wb_rd, mem_wb_write, o_fault, 32'(o_req)} !== {32'hCAFE_F00D, 5'd6, 1'b1, 1'b0, 32'(TO)}) begin
            errors++;
            $display("FAIL ready_last_cycle: got %h/%0d/%b fault=%b req=%0d expected cafef00d/6/1/0/%0d",
                     mem_wb_result, mem_wb_rd, mem_wb_write, o_fault, o_req, TO);
        end
    endtask

    task automatic test_reset_access;
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd2, 1'b1);
        tick;
        set_idle;
        tick;
        checks++;
        if ({mem_req, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL sw_second_access: got req=%b we=%b expected 1/1", mem_req, mem_we);
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({mem_req, mem_we, mem_busy, mem_fault, mem_wb_write, mem_wstrb, mem_wb_rd, mem_wb_result} !== 45'h0) begin
            errors++;
            $display("FAIL reset_in_access: got req=%b we=%b busy=%b fault=%b wbw=%b strb=%b rd=%0d res=%h expected all zero",
                     mem_req, mem_we, mem_busy, mem_fault, mem_wb_write, mem_wstrb, mem_wb_rd, mem_wb_result);
        end
        reset = 1'b0;
        tick;
        checks++;
        if ({mem_req, mem_fault, mem_wb_write, mem_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL after_reset: got req=%b fault=%b wbw=%b busy=%b expected 0000",
                     mem_req, mem_fault, mem_wb_write, mem_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic        ld, st, w;
        logic [2:0]  ty;
        logic [31:0] a, d, res, rdata;
        logic [4:0]  r;
        int          wait_n, kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            ld = (kind == 1) || (kind == 2) || (kind == 4);
            st = (kind == 3) || (kind == 4);
            ty = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d = $urandom; res = $urandom; rdata = $urandom; r = 5'($urandom); w = 1'($urandom);
            wait_n = $urandom_range(0, TO - 1);
            drive(ld, st, ty, a, d, res, r, w);
            run_op(rdata, wait_n);
            checks++;
            if (!o_done) begin
                errors++;
                $display("FAIL rand%0d_done: op never completed within 20 cycles", i);
            end else if (!ld && !st) begin
                if ({mem_wb_result, mem_wb_rd, mem_wb_write, o_fault, 32'(o_busy)} !== {res, r, w, 1'b0, 32'd0}) begin
                    errors++;
                    $display("FAIL rand%0d_alu: got %h/%0d/%b fault=%b busy=%0d expected %h/%0d/%b/0/0",
                             i, mem_wb_result, mem_wb_rd, mem_wb_write, o_fault, o_busy, res, r, w);
                end
            end else if (!is_legal(ld, st, ty, a)) begin
                if ({32'(o_req), 32'(o_busy), o_fault, mem_wb_write} !== {32'd0, 32'd0, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL rand%0d_fault: ld=%b st=%b ty=%0d a=%h got req=%0d busy=%0d fault=%b wbw=%b expected 0/0/1/0",
                             i, ld, st, ty, a, o_req, o_busy, o_fault, mem_wb_write);
                end
            end else if (ld) begin
                if ({32'(o_busy), 32'(o_req), o_addr, o_we, o_wstrb, o_stable, o_fault,
                     mem_wb_result, mem_wb_rd, mem_wb_write} !==
                    {32'(wait_n + 2), 32'(wait_n + 1), a & 32'hFFFF_FFFC, 1'b0, 4'h0, 1'b1, 1'b0,
                     exp_load(ty, a, rdata), r, w}) begin
                    errors++;
                    $display("FAIL rand%0d_load: ty=%0d a=%h got busy=%0d req=%0d addr=%h res=%h rd=%0d w=%b expected %0d/%0d/%h/%h/%0d/%b",
                             i, ty, a, o_busy, o_req, o_addr, mem_wb_result, mem_wb_rd, mem_wb_write,
                             wait_n + 2, wait_n + 1, a & 32'hFFFF_FFFC, exp_load(ty, a, rdata), r, w);
                end
            end else begin
                if ({32'(o_busy), 32'(o_req), o_addr, o_we, o_wstrb, o_wdata, o_stable, o_fault, mem_wb_write} !==
                    {32'(wait_n + 2), 32'(wait_n + 1), a & 32'hFFFF_FFFC, 1'b1, exp_strb(ty, a),
                     exp_wdata(ty, d), 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL rand%0d_store: ty=%0d a=%h got busy=%0d req=%0d addr=%h strb=%b wdata=%h wbw=%b expected %0d/%0d/%h/%b/%h/0",
                             i, ty, a, o_busy, o_req, o_addr, o_wstrb, o_wdata, mem_wb_write,
                             wait_n + 2, wait_n + 1, a & 32'hFFFF_FFFC, exp_strb(ty, a), exp_wdata(ty, d));
                end
            end
        end
    endtask

    initial begin
        set_idle;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        test_reset;
        test_alu;
        test_load_byte;
        test_store_half;
        test_fault;
        test_timeout;
        test_reset_access;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
